// File: rtl/ultrasound_sweep_locator.sv
// Ultrasonic ranger sweep: fires each ranger in turn, times its echo
// and publishes the nearest return as {dist, sector} at sweep end.
module ultrasound_sweep_locator #(
  parameter int N_SENSORS       = 12,
  parameter int TRIGGER_CYCLES  = 650,
  parameter int RISE_TIMEOUT    = 65000,
  parameter int CYCLES_PER_UNIT = 9620,
  parameter int MAX_DIST        = 255,
  parameter int GAP_CYCLES      = 3900000,
  parameter int NEW_DATA_HOLD   = 1100000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trigger,
  output logic [11:0]          location,
  output logic                 new_data,
  output logic                 sweep_done,
  output logic                 no_target,
  output logic                 busy
);

  localparam int CW = $clog2(TRIGGER_CYCLES + RISE_TIMEOUT
                           + CYCLES_PER_UNIT + GAP_CYCLES + 1);
  localparam int HW = $clog2(NEW_DATA_HOLD + 1);
  localparam logic [7:0] DMAX = 8'(MAX_DIST);

  typedef enum logic [2:0] {
    IDLE, TRIGGER, WAIT_RISE, MEASURE, GAP, REPORT
  } state_t;

  state_t               state_q, state_d;
  logic [N_SENSORS-1:0] echo_s1_q, echo_s1_d;
  logic [N_SENSORS-1:0] echo_s2_q, echo_s2_d;
  logic [3:0]           idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           dist_q, dist_d;
  logic [7:0]           best_dist_q, best_dist_d;
  logic [3:0]           best_idx_q, best_idx_d;
  logic                 found_q, found_d;
  logic [11:0]          loc_q, loc_d;
  logic                 nt_q, nt_d;
  logic [HW-1:0]        hold_q, hold_d;

  logic [N_SENSORS-1:0] sel;
  logic                 echo_cur;
  logic                 cnt_wrap;
  logic [7:0]           dist_inc;

  // Selected ranger, its synchronized echo and the per-unit distance step
  always_comb begin
    sel      = N_SENSORS'(1) << idx_q;
    echo_cur = |(echo_s2_q & sel);
    cnt_wrap = (cnt_q == CW'(CYCLES_PER_UNIT - 1));
    dist_inc = (cnt_wrap && dist_q != DMAX) ? dist_q + 8'd1 : dist_q;
  end

  // Sweep FSM next-state, counters, best-return tracking and report
  always_comb begin
    state_d     = state_q;
    echo_s1_d   = echo;
    echo_s2_d   = echo_s1_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    dist_d      = dist_q;
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;
    found_d     = found_q;
    loc_d       = loc_q;
    nt_d        = nt_q;
    hold_d      = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = TRIGGER;
          idx_d       = 4'd0;
          cnt_d       = '0;
          best_dist_d = DMAX;
          found_d     = 1'b0;
        end
      end
      TRIGGER: begin
        if (cnt_q == CW'(TRIGGER_CYCLES - 1)) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_RISE: begin
        if (echo_cur) begin
          state_d = MEASURE;
          cnt_d   = '0;
          dist_d  = 8'd0;
        end else if (cnt_q == CW'(RISE_TIMEOUT - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MEASURE: begin
        cnt_d  = cnt_wrap ? '0 : cnt_q + CW'(1);
        dist_d = dist_inc;
        if (dist_inc == DMAX) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (!echo_cur) begin
          state_d = GAP;
          cnt_d   = '0;
          if (dist_inc < best_dist_q) begin
            best_dist_d = dist_inc;
            best_idx_d  = idx_q;
            found_d     = 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (idx_q == 4'(N_SENSORS - 1)) begin
            state_d = REPORT;
          end else begin
            state_d = TRIGGER;
            idx_d   = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPORT: begin
        nt_d = !found_q;
        if (found_q) begin
          loc_d  = {best_dist_q, best_idx_q};
          hold_d = HW'(NEW_DATA_HOLD);
        end
        if (enable) begin
          state_d     = TRIGGER;
          idx_d       = 4'd0;
          cnt_d       = '0;
          best_dist_d = DMAX;
          found_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      echo_s1_q   <= '0;
      echo_s2_q   <= '0;
      idx_q       <= 4'd0;
      cnt_q       <= '0;
      dist_q      <= 8'd0;
      best_dist_q <= 8'd0;
      best_idx_q  <= 4'd0;
      found_q     <= 1'b0;
      loc_q       <= 12'd0;
      nt_q        <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      echo_s1_q   <= echo_s1_d;
      echo_s2_q   <= echo_s2_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      dist_q      <= dist_d;
      best_dist_q <= best_dist_d;
      best_idx_q  <= best_idx_d;
      found_q     <= found_d;
      loc_q       <= loc_d;
      nt_q        <= nt_d;
      hold_q      <= hold_d;
    end
  end

  // Trigger is gated by reset so a mid-sweep reset drops it immediately
  always_comb begin
    trigger    = (state_q == TRIGGER && !reset) ? sel : '0;
    sweep_done = (state_q == REPORT);
    busy       = (state_q != IDLE);
    location   = loc_q;
    no_target  = nt_q;
    new_data   = (hold_q != '0);
  end

endmodule

// File: tb/tb_ultrasound_sweep_locator.sv
// Bench for ultrasound_sweep_locator: ranger echo responder, sweep
// vector table with a result scoreboard, and reset/trigger corner cases.
module tb_ultrasound_sweep_locator;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  echo;
  logic [3:0]  trigger;
  logic [11:0] location;
  logic        new_data;
  logic        sweep_done;
  logic        no_target;
  logic        busy;

  always #5 clock = ~clock;

  ultrasound_sweep_locator #(
    .N_SENSORS(4), .TRIGGER_CYCLES(4), .RISE_TIMEOUT(20),
    .CYCLES_PER_UNIT(10), .MAX_DIST(255), .GAP_CYCLES(8),
    .NEW_DATA_HOLD(50)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .echo(echo),
    .trigger(trigger), .location(location), .new_data(new_data),
    .sweep_done(sweep_done), .no_target(no_target), .busy(busy)
  );

  typedef struct { int w[4]; logic [11:0] loc; logic nt; } vec_t;
  typedef struct { logic [11:0] loc; logic nt; } exp_t;
  typedef struct { logic [3:0] v; int len; } run_t;

  vec_t tbl[9];
  exp_t sb[$];
  run_t trig_runs[$];
  int   nd_runs[$];
  int   onehot_viol = 0;
  int   w[4];
  bit   abort = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int i, input int a, input int b, input int c,
                     input int d, input logic [11:0] l, input logic n);
    tbl[i].w[0] = a;
    tbl[i].w[1] = b;
    tbl[i].w[2] = c;
    tbl[i].w[3] = d;
    tbl[i].loc  = l;
    tbl[i].nt   = n;
  endtask

  task automatic push_exp(input logic [11:0] l, input logic n);
    exp_t e;
    e.loc = l;
    e.nt  = n;
    sb.push_back(e);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clock);
      if (sweep_done) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL sweep_done_timeout: got no pulse expected one");
    end
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    @(negedge clock);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb_underflow: got report expected none", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_location"}, location, e.loc);
      chk({tag, "_no_target"}, no_target, e.nt);
      chk({tag, "_new_data"}, new_data, !e.nt);
      chk({tag, "_done_pulse"}, sweep_done, 1'b0);
    end
  endtask

  task automatic wait_echo(input logic [3:0] val, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clock);
      if (echo == val) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL echo_wait_timeout: got %0h expected %0h", echo, val);
    end
  endtask

  // Ranger model: echo rises 3 clocks after its trigger falls
  initial begin : responder
    int dly[4];
    int rem[4];
    logic [3:0] tprev;
    echo  = '0;
    tprev = '0;
    for (int k = 0; k < 4; k++) begin
      dly[k] = 0;
      rem[k] = 0;
    end
    forever begin
      @(posedge clock);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (abort) begin
          dly[k]  = 0;
          rem[k]  = 0;
          echo[k] = 1'b0;
        end else if (echo[k]) begin
          rem[k]--;
          if (rem[k] == 0) echo[k] = 1'b0;
        end else if (dly[k] > 0) begin
          dly[k]--;
          if (dly[k] == 0) echo[k] = 1'b1;
        end else if (tprev[k] && !trigger[k] && w[k] > 0) begin
          dly[k] = 3;
          rem[k] = w[k];
        end
      end
      tprev = trigger;
    end
  end

  // Trigger run and new_data run recorders
  initial begin : monitors
    logic [3:0] tr_prev = '0;
    int tr_len = 0;
    int nd_len = 0;
    forever begin
      @(negedge clock);
      if (trigger != tr_prev && tr_prev != '0)
        trig_runs.push_back('{v: tr_prev, len: tr_len});
      if (trigger != tr_prev) tr_len = 1;
      else tr_len++;
      tr_prev = trigger;
      if ($countones(trigger) > 1) onehot_viol++;
      if (new_data) begin
        nd_len++;
      end else if (nd_len > 0) begin
        nd_runs.push_back(nd_len);
        nd_len = 0;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit ok;
    int n_runs;
    reset  = 1'b1;
    enable = 1'b0;
    for (int k = 0; k < 4; k++) w[k] = 0;
    repeat (3) @(negedge clock);
    chk("rst_trigger", trigger, 4'h0);
    chk("rst_location", location, 12'h000);
    chk("rst_new_data", new_data, 1'b0);
    chk("rst_sweep_done", sweep_done, 1'b0);
    chk("rst_no_target", no_target, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;

    add(0, 120, 50, 50, 200, 12'h051, 1'b0);
    add(1, 0, 0, 0, 0, 12'h051, 1'b1);
    add(2, 0, 0, 0, 95, 12'h093, 1'b0);
    add(3, 25, 25, 0, 0, 12'h020, 1'b0);
    add(4, 2550, 0, 0, 0, 12'h020, 1'b1);
    add(5, 9, 0, 0, 0, 12'h000, 1'b0);
    add(6, 0, 0, 0, 2549, 12'hFE3, 1'b0);
    add(7, 0, 0, 0, 0, 12'hFE3, 1'b1);
    add(8, 3000, 0, 30, 0, 12'h032, 1'b0);

    w = tbl[0].w;
    push_exp(tbl[0].loc, tbl[0].nt);
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_done(ok);
      if (i < 8) begin
        w = tbl[i+1].w;
        push_exp(tbl[i+1].loc, tbl[i+1].nt);
      end else begin
        enable = 1'b0;
      end
      if (ok) sb_check($sformatf("vec%0d", i));
    end

    n_runs = trig_runs.size();
    chk("trig_run_count", n_runs, 36);
    for (int j = 0; j < n_runs && j < 36; j++) begin
      chk($sformatf("trig_val%0d", j), trig_runs[j].v, 32'd1 << (j % 4));
      chk($sformatf("trig_len%0d", j), trig_runs[j].len, 4);
    end

    wait_echo(4'h0, 2000);
    for (int k = 0; k < 4; k++) w[k] = 0;
    w[0] = 500;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    wait_echo(4'h1, 200);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    abort = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_rst_trigger", trigger, 4'h0);
    chk("mid_rst_location", location, 12'h000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_sweep_done", sweep_done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    abort = 1'b0;
    w[0] = 0;
    w[1] = 60;
    push_exp(12'h061, 1'b0);
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    wait_done(ok);
    if (ok) sb_check("post_rst");
    chk("sb_empty", sb.size(), 0);

    repeat (60) @(negedge clock);
    chk("nd_run_count", nd_runs.size(), 7);
    foreach (nd_runs[j]) chk($sformatf("nd_len%0d", j), nd_runs[j], 50);
    chk("trigger_onehot", onehot_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
